// File: rtl/axis_split_x2.sv
// AXI-Stream width splitter: one DWIDTH_IN word in, two DWIDTH_OUT beats out (lower half first).
// Optional packet framing via `define AXIS_SPLIT_TLAST_EN (tlast follows the upper-half beat).
module axis_split_x2 #(
  parameter int DWIDTH_IN  = 256,
  parameter int DWIDTH_OUT = 128
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
`ifdef AXIS_SPLIT_TLAST_EN
  input  logic                  s_axis_tlast,
`endif
  output logic [DWIDTH_OUT-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef AXIS_SPLIT_TLAST_EN
  ,
  output logic                  m_axis_tlast
`endif
);

  generate
    if (DWIDTH_IN != 2 * DWIDTH_OUT) begin : g_width_check
      $error("axis_split_x2: DWIDTH_IN must equal 2*DWIDTH_OUT");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DWIDTH_IN-1:0]   r_held;
  logic                   w_capture;
  logic                   w_ready;
`ifdef AXIS_SPLIT_TLAST_EN
  logic                   r_last;
`endif

  // State register and holding register; reset discards any half still pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
`ifdef AXIS_SPLIT_TLAST_EN
      r_last  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_held <= s_axis_tdata;
`ifdef AXIS_SPLIT_TLAST_EN
        r_last <= s_axis_tlast;
`endif
      end
    end
  end

  // Next-state and input-side handshake; HI accepts a new word only when its upper half leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (s_axis_tvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LO: begin
        if (m_axis_tready) begin
          w_state_nxt = ST_HI;
        end else begin
          w_state_nxt = ST_LO;
        end
      end
      ST_HI: begin
        w_ready = m_axis_tready;
        if (m_axis_tready) begin
          if (s_axis_tvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_LO;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_HI;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // s_axis_tready carries a combinational path from m_axis_tready (HI) and areset.
  assign s_axis_tready = w_ready & ~areset;

  // Output side decodes registered state only.
  assign m_axis_tvalid = (r_state == ST_LO) || (r_state == ST_HI);
  assign m_axis_tdata  = (r_state == ST_HI) ? r_held[DWIDTH_IN-1:DWIDTH_OUT]
                                            : r_held[DWIDTH_OUT-1:0];
`ifdef AXIS_SPLIT_TLAST_EN
  assign m_axis_tlast  = (r_state == ST_HI) & r_last;
`endif

endmodule

// File: doc/axis_split_x2.md
AXIS_SPLIT_X2 -- requirements
Module: axis_split_x2

Interface
REQ-001 Parameter DWIDTH_IN, default 256: input word width in bits.
REQ-002 Parameter DWIDTH_OUT, default 128: output beat width in bits; DWIDTH_IN SHALL equal 2*DWIDTH_OUT, otherwise elaboration SHALL fail.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  input  DWIDTH_IN  wide input word.
REQ-006 s_axis_tvalid  input  1  input word valid.
REQ-007 s_axis_tready  output  1  block accepts input word this cycle.
REQ-008 s_axis_tlast  input  1  last word of packet (present only with AXIS_SPLIT_TLAST_EN).
REQ-009 m_axis_tdata  output  DWIDTH_OUT  narrow output beat.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  downstream accepts beat.
REQ-012 m_axis_tlast  output  1  last beat of packet (present only with AXIS_SPLIT_TLAST_EN).

Function
REQ-013 Input transfer occurs when s_axis_tvalid & s_axis_tready; output transfer when m_axis_tvalid & m_axis_tready; both are true AXI-Stream handshakes.
REQ-014 States: IDLE (nothing held), LO (word held, lower half presented), HI (upper half presented).
REQ-015 Accepted word SHALL be stored in one DWIDTH_IN holding register; no other data storage.
REQ-016 IDLE: s_axis_tready=1, m_axis_tvalid=0; on input transfer capture word, go to LO.
REQ-017 LO: s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=held[DWIDTH_OUT-1:0]; on output transfer go to HI, else stay.
REQ-018 HI: m_axis_tvalid=1, m_axis_tdata=held[DWIDTH_IN-1:DWIDTH_OUT]; s_axis_tready=m_axis_tready (combinational path, documented).
REQ-019 HI with output transfer and input transfer same cycle: capture new word, go to LO (no bubble).
REQ-020 HI with output transfer and no input: go to IDLE.
REQ-021 HI without m_axis_tready: stay, held word and m_axis_tdata unchanged.
REQ-022 Latency: word accepted at edge N appears as lower half on m_axis_tdata in cycle after edge N; upper half follows on next output transfer.
REQ-023 Sustained throughput with s_axis_tvalid and m_axis_tready held high: one output beat every cycle, one input word every two cycles.
REQ-024 m_axis_tdata, m_axis_tvalid SHALL depend only on registered state (no combinational path from inputs).
REQ-025 Lower half SHALL always precede upper half; no half is dropped or duplicated.

Reset
REQ-026 areset high at a clock edge: state->IDLE, holding register->0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0 while areset high.
REQ-027 areset mid-word (LO or HI) SHALL discard the held word; no remaining half is emitted after reset release.
REQ-028 First cycle after reset release: s_axis_tready=1.

Configuration
REQ-029 Macro AXIS_SPLIT_TLAST_EN defined: s_axis_tlast captured with the word; m_axis_tlast=0 in LO, =captured tlast in HI.
REQ-030 Macro AXIS_SPLIT_TLAST_EN undefined: s_axis_tlast, m_axis_tlast ports and their register absent; all other behaviour identical.

Verification
REQ-031 Reset then one word 0x{FFFF...FFFF_0000...0001} (upper=all ones, lower=1), m_axis_tready=1 -> beats 0x...0001 then 0xFF...FF on consecutive cycles, then m_axis_tvalid=0.
REQ-032 Continuous valid words W0..W7 (incrementing counters), m_axis_tready=1 -> 16 beats, W0lo,W0hi,...,W7hi, no gaps, s_axis_tready toggles 1/0.
REQ-033 m_axis_tready random 50% -> output sequence identical to REQ-032, data stable while m_axis_tvalid & !m_axis_tready.
REQ-034 areset asserted in HI with word W5 held -> W5 upper half never emitted; next word after release appears lower half first.
REQ-035 With AXIS_SPLIT_TLAST_EN, 3-word packet tlast on word 3 -> m_axis_tlast=1 only on beat 6 (upper half of word 3).
